// File: rtl/alu_host_driver.sv
// Host-side sequencer for the 8-bit multi-cycle ALU: request -> BEGIN/LOAD/WAIT/capture -> response.
// Optional WAIT_END abort enabled by defining ALU_DRIVER_TIMEOUT_EN.
module alu_host_driver #(
  parameter int WORD_HOLD      = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_x,
  input  logic [7:0]  req_y,
  input  logic [7:0]  req_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        alu_begin,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end
);

  typedef enum logic [2:0] {
    S_IDLE, S_BEGIN, S_LOAD, S_WAIT, S_CAP_HI, S_CAP_LO, S_RESP
  } state_t;

  localparam logic [1:0]       OP_DIV    = 2'b11;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(WORD_HOLD - 1);

  state_t           state, nstate;
  logic [1:0]       op_q, op_n;
  logic [7:0]       x_q, y_q, z_q, hi_q, lo_q;
  logic [1:0]       widx_q, widx_n, widx_last;
  logic [CNT_W-1:0] hold_q, hold_n;
  logic             accept, timed_out;

  logic             req_ready_d, busy_d, alu_begin_d, rsp_valid_d;
  logic [1:0]       alu_op_code_d;
  logic [7:0]       alu_inbus_d;
  logic [15:0]      rsp_result_d;

  assign accept    = (state == S_IDLE) && req_valid && req_ready;
  assign widx_last = (op_q == OP_DIV) ? 2'd2 : 2'd1;

`ifdef ALU_DRIVER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tcnt_q;

  // END in the same cycle as the limit takes priority over the abort
  assign timed_out = (state == S_WAIT) && !alu_end && (tcnt_q >= TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_q      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state != S_WAIT)      tcnt_q <= '0;
      else if (tcnt_q < TO_LAST) tcnt_q <= tcnt_q + 1'b1;
      rsp_timeout <= (nstate == S_RESP) && ((state == S_RESP) ? rsp_timeout : timed_out);
    end
  end
`else
  assign timed_out   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register and datapath captures
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      widx_q      <= '0;
      hold_q      <= '0;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      alu_begin   <= 1'b0;
      alu_op_code <= '0;
      alu_inbus   <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
    end else begin
      state  <= nstate;
      widx_q <= widx_n;
      hold_q <= hold_n;
      if (accept) begin
        op_q <= req_op;
        x_q  <= req_x;
        y_q  <= req_y;
        z_q  <= req_z;
      end
      if (state == S_WAIT && alu_end) hi_q <= alu_outbus;
      if (state == S_CAP_HI)          lo_q <= alu_outbus;
      req_ready   <= req_ready_d;
      busy        <= busy_d;
      alu_begin   <= alu_begin_d;
      alu_op_code <= alu_op_code_d;
      alu_inbus   <= alu_inbus_d;
      rsp_valid   <= rsp_valid_d;
      rsp_result  <= rsp_result_d;
    end
  end

  // Next state and operand-word sequencing
  always_comb begin
    nstate = state;
    widx_n = widx_q;
    hold_n = hold_q;
    case (state)
      S_IDLE:   if (accept) nstate = S_BEGIN;
      S_BEGIN: begin
        nstate = S_LOAD;
        widx_n = '0;
        hold_n = '0;
      end
      S_LOAD: begin
        if (hold_q >= HOLD_LAST) begin
          hold_n = '0;
          if (widx_q >= widx_last) nstate = S_WAIT;
          else                     widx_n = widx_q + 2'd1;
        end else begin
          hold_n = hold_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (alu_end)        nstate = S_CAP_HI;
        else if (timed_out) nstate = S_RESP;
      end
      S_CAP_HI: nstate = S_CAP_LO;
      S_CAP_LO: nstate = S_RESP;
      S_RESP:   if (rsp_ready) nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers aligned with it
  always_comb begin
    op_n          = accept ? req_op : op_q;
    req_ready_d   = (nstate == S_IDLE);
    busy_d        = (nstate != S_IDLE);
    alu_begin_d   = (nstate == S_BEGIN);
    rsp_valid_d   = (nstate == S_RESP);
    alu_op_code_d = '0;
    alu_inbus_d   = '0;
    rsp_result_d  = '0;
    if (nstate inside {S_BEGIN, S_LOAD, S_WAIT, S_CAP_HI, S_CAP_LO})
      alu_op_code_d = op_n;
    if (nstate == S_LOAD) begin
      case (widx_n)
        2'd0:    alu_inbus_d = x_q;
        2'd1:    alu_inbus_d = y_q;
        default: alu_inbus_d = z_q;
      endcase
    end
    if (nstate == S_RESP) begin
      if (state == S_CAP_LO)    rsp_result_d = {hi_q, lo_q};
      else if (state == S_RESP) rsp_result_d = rsp_result;
    end
  end

endmodule

// File: tb/tb_alu_host_driver.sv
// Directed bench for alu_host_driver: two instances (WORD_HOLD 1 and 2) driven from negedge tasks.
module tb_alu_host_driver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0]       req_valid = '0, rsp_ready = '0, alu_end = '0;
  logic [1:0][1:0]  req_op = '0;
  logic [1:0][7:0]  req_x = '0, req_y = '0, req_z = '0, alu_outbus = '0;
  wire  [1:0]       req_ready, rsp_valid, rsp_timeout, busy, alu_begin;
  wire  [1:0][15:0] rsp_result;
  wire  [1:0][1:0]  alu_op_code;
  wire  [1:0][7:0]  alu_inbus;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_host_driver #(.WORD_HOLD(g + 1), .TIMEOUT_CYCLES(10), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_op(req_op[g]),
      .req_x(req_x[g]), .req_y(req_y[g]), .req_z(req_z[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_result(rsp_result[g]),
      .rsp_timeout(rsp_timeout[g]), .busy(busy[g]), .alu_begin(alu_begin[g]),
      .alu_op_code(alu_op_code[g]), .alu_inbus(alu_inbus[g]),
      .alu_outbus(alu_outbus[g]), .alu_end(alu_end[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input int d);
    chk("rst_req_ready", req_ready[d], 0);
    chk("rst_busy", busy[d], 0);
    chk("rst_begin", alu_begin[d], 0);
    chk("rst_op_code", alu_op_code[d], 0);
    chk("rst_inbus", alu_inbus[d], 0);
    chk("rst_rsp_valid", rsp_valid[d], 0);
    chk("rst_rsp_result", rsp_result[d], 0);
    chk("rst_rsp_timeout", rsp_timeout[d], 0);
  endtask

  // Full operation up to the first RESP cycle; instance d has WORD_HOLD d+1
  task automatic run_op(input int d, input logic [1:0] op, input logic [7:0] x, y, z,
                        input logic [7:0] hi, lo, input bit end_in_load);
    logic [7:0] w [3];
    int nw;
    w[0] = x; w[1] = y; w[2] = z;
    nw = (op == 2'b11) ? 3 : 2;
    chk("req_ready_idle", req_ready[d], 1);
    req_valid[d] = 1'b1; req_op[d] = op; req_x[d] = x; req_y[d] = y; req_z[d] = z;
    cyc();
    chk("begin_pulse", alu_begin[d], 1);
    chk("begin_op", alu_op_code[d], op);
    chk("begin_ready_low", req_ready[d], 0);
    chk("begin_busy", busy[d], 1);
    req_valid[d] = 1'b0;
    for (int i = 0; i < nw; i++)
      for (int h = 0; h <= d; h++) begin
        cyc();
        alu_end[d] = 1'b0;
        chk("load_inbus", alu_inbus[d], w[i]);
        chk("load_begin_low", alu_begin[d], 0);
        chk("load_op", alu_op_code[d], op);
        if (end_in_load && i == 0 && h == 0) begin
          alu_end[d] = 1'b1; alu_outbus[d] = 8'hAA;
        end
      end
    cyc();
    alu_end[d] = 1'b0;
    chk("wait_inbus_zero", alu_inbus[d], 0);
    chk("wait_op", alu_op_code[d], op);
    chk("wait_no_rsp", rsp_valid[d], 0);
    alu_end[d] = 1'b1; alu_outbus[d] = hi;
    cyc();
    alu_end[d] = 1'b0; alu_outbus[d] = lo;
    cyc();
    alu_outbus[d] = 8'h00;
    chk("caplo_no_rsp", rsp_valid[d], 0);
    cyc();
    chk("rsp_valid", rsp_valid[d], 1);
    chk("rsp_result", rsp_result[d], {hi, lo});
    chk("rsp_timeout_low", rsp_timeout[d], 0);
    chk("rsp_op_zero", alu_op_code[d], 0);
    chk("rsp_busy", busy[d], 1);
  endtask

  // Hold the response for 'hold' cycles with a stray request pending, then consume it
  task automatic finish_rsp(input int d, input int hold, input logic [15:0] exp, input logic exp_to);
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1; req_x[d] = 8'hEE;
      cyc();
      chk("hold_valid", rsp_valid[d], 1);
      chk("hold_result", rsp_result[d], exp);
      chk("hold_timeout", rsp_timeout[d], exp_to);
      chk("hold_ready_low", req_ready[d], 0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    cyc();
    rsp_ready[d] = 1'b0;
    chk("post_rsp_valid", rsp_valid[d], 0);
    chk("post_rsp_timeout", rsp_timeout[d], 0);
    chk("post_req_ready", req_ready[d], 1);
    chk("post_busy", busy[d], 0);
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk_all_zero(0);
    chk_all_zero(1);
    reset = 1'b1;
    cyc();
    chk("ready_after_rst0", req_ready[0], 1);
    chk("ready_after_rst1", req_ready[1], 1);

    // add 12+34, WORD_HOLD=1
    run_op(0, 2'b00, 8'h12, 8'h34, 8'h77, 8'h00, 8'h46, 1'b0);
    finish_rsp(0, 0, 16'h0046, 1'b0);

    // div 0x0100/0x10, WORD_HOLD=2, response stalled 5 cycles
    run_op(1, 2'b11, 8'h01, 8'h00, 8'h10, 8'h10, 8'h00, 1'b0);
    finish_rsp(1, 5, 16'h1000, 1'b0);

    // Reset during LOAD aborts the operation
    chk("pre_rst_ready", req_ready[1], 1);
    req_valid[1] = 1'b1; req_op[1] = 2'b10; req_x[1] = 8'h05; req_y[1] = 8'h06;
    cyc();
    req_valid[1] = 1'b0;
    cyc();
    chk("mid_load_inbus", alu_inbus[1], 8'h05);
    reset = 1'b0;
    cyc();
    chk_all_zero(1);
    reset = 1'b1;
    cyc();
    chk("ready_after_midrst", req_ready[1], 1);
    chk("idle_after_midrst", busy[1], 0);
    run_op(1, 2'b01, 8'h50, 8'h20, 8'h00, 8'h00, 8'h30, 1'b0);
    finish_rsp(1, 0, 16'h0030, 1'b0);

    // END pulse during LOAD is ignored
    run_op(0, 2'b10, 8'h03, 8'h04, 8'h00, 8'h00, 8'h0C, 1'b1);
    finish_rsp(0, 1, 16'h000C, 1'b0);

    // END never arrives
    req_valid[0] = 1'b1; req_op[0] = 2'b00; req_x[0] = 8'h01; req_y[0] = 8'h02;
    cyc();
    req_valid[0] = 1'b0;
    cyc(); cyc(); cyc();
    chk("to_wait_no_rsp", rsp_valid[0], 0);
`ifdef ALU_DRIVER_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("to_still_waiting", rsp_valid[0], 0);
    end
    cyc();
    chk("to_rsp_valid", rsp_valid[0], 1);
    chk("to_flag", rsp_timeout[0], 1);
    chk("to_result_zero", rsp_result[0], 0);
    finish_rsp(0, 2, 16'h0000, 1'b1);
`else
    repeat (40) cyc();
    chk("noto_busy", busy[0], 1);
    chk("noto_no_rsp", rsp_valid[0], 0);
    chk("noto_timeout_low", rsp_timeout[0], 0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    chk("noto_recover_ready", req_ready[0], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
